signed_result_display: RTL and testbench
========================================

Name: signed_result_display

Overview:
- Consumes the 6-bit two's-complement result and overflow flag from the ALU arithmetic units and renders the value on a 4-digit multiplexed seven-segment display.
- Performs sign/magnitude split, iterative binary-to-BCD conversion (double dabble) and a digit-scan state machine.
- Sits between the ALU result mux and the board display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances; must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- val  in  6  two's-complement value to display (range -32..+31)
- ovf  in  1  overflow flag accompanying val
- load  in  1  capture request; honoured only when busy=0
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse when the new value reaches the display registers
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  out  4  digit enables, active-low one-hot; an_n[0] is the rightmost digit

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state changes occur on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - FSM returns to IDLE; busy=0; done=0.
  - All four digit registers are set to blank; seg_n=7'h7F.
  - Scan counter is cleared; an_n=4'b1110.
  - Reset mid-conversion abandons the conversion; the display stays blank until the next load.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: when load=1 at edge N, capture val and ovf. neg=val[5]; mag=neg ? (~val+1) : val, computed 7 bits wide so that -32 gives 32. Go to CONV; busy=1 from edge N.
  - CONV: one double-dabble shift per cycle for 6 cycles (edges N+1..N+6). Before each shift, add 3 to any BCD nibble that is >=5. Go to COMMIT.
  - COMMIT (edge N+7): write the digit registers; done=1 for exactly this cycle; busy=0; return to IDLE. A load seen in the cycle after COMMIT is accepted.
- load while busy=1 is ignored; there is no queueing.
- Latency: the display registers show the new value 7 cycles after the load edge.
- Digit mapping when ovf=0:
  - digit3 is blank.
  - digit2 is '-' if neg, otherwise blank.
  - digit1 is tens, or blank when tens=0.
  - digit0 is ones and is always shown, so 0 displays as "0".
- Digit mapping when ovf=1: digit3 and digit2 blank, digit1 'O', digit0 'F'. The value is ignored; the conversion still takes 7 cycles.
- Segment codes (seg_n, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, 'O'=1000000, 'F'=0001110, blank=1111111
- Scan:
  - A free-running counter of 0..SCAN_DIV-1 advances the digit index on wrap: 0→1→2→3→0.
  - an_n is the active-low one-hot of the index; seg_n is the registered code of the selected digit, aligned in the same cycle as an_n.
  - The scan is unaffected by load, busy or COMMIT. A commit changes seg_n from the next cycle without glitching an_n.
- Boundaries:
  - -32 (100000): magnitude 32 → "-32".
  - +31 (011111): "31".
  - -1 (111111): "-1", tens blank.

Test Plan:
- SCAN_DIV=4, reset, no load → seg_n=7'h7F on every digit; an_n cycles 1110,1101,1011,0111, changing every 4 cycles.
- load with val=6'b000111, ovf=0 → busy high for 7 cycles, done pulses at load+7; digits {blank, blank, blank, '7'}; seg_n=1111000 when an_n=1110.
- val=6'b100000 (-32) → digit2 '-'=0111111, digit1 '3'=0110000, digit0 '2'=0100100. Then val=6'b011111 → digit2 blank, digit1 '3', digit0 '1'=1111001.
- val=6'b000000 → only digit0 shows '0'=1000000. Then val=6'b111011, ovf=1 → digit1 'O'=1000000, digit0 'F'=0001110, digit2 blank.
- load val=5, then at load+3 assert load with val=9 → 9 is ignored; done at load+7 only; display shows "5"; busy stays high throughout.
- load val=-12, then rst_n=0 at load+4 for one cycle → busy=0, done never pulses, all digits blank, an_n=1110; a subsequent load of -12 shows "-12".

Source files
------------

// File: rtl/signed_result_display_if.sv
// Bus between the ALU result mux and the signed display block: captured value,
// overflow flag, load handshake, and the multiplexed seven-segment outputs.
interface signed_result_display_if;
  logic [5:0] val;
  logic       ovf;
  logic       load;
  logic       busy;
  logic       done;
  logic [6:0] seg_n;
  logic [3:0] an_n;

  modport master (output val, ovf, load, input busy, done, seg_n, an_n);
  modport slave  (input val, ovf, load, output busy, done, seg_n, an_n);
endinterface

// File: rtl/signed_result_display.sv
// Signed 6-bit result display: sign/magnitude split, double-dabble BCD
// conversion over six cycles, then a free-running 4-digit scan of
// active-low seven-segment codes.
module signed_result_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                     clk,
  input logic                     rst_n,
  signed_result_display_if.slave  bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  shift_q;
  logic [5:0]  sh_q;
  logic [7:0]  bcd_q;
  logic        neg_q;
  logic        ovf_q;
  logic        done_q;
  logic [6:0]  dig_q [4];
  logic [CW-1:0] scan_q;
  logic [1:0]  idx_q;

  logic [5:0]  mag;
  logic [7:0]  bcd_adj;
  logic [13:0] dd_next;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Magnitude and one double-dabble step (add-3 on nibbles >= 5, then shift).
  // Six bits suffice for the unsigned magnitude: -32 negates to 6'b100000 = 32.
  always_comb begin
    mag        = bus.val[5] ? (~bus.val + 6'd1) : bus.val;
    bcd_adj    = bcd_q;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    dd_next    = {bcd_adj, sh_q} << 1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: capture on load, six shift cycles, one commit cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = CONV;
      CONV:    if (shift_q == 3'd5) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath and digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) dig_q[i] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            neg_q   <= bus.val[5];
            ovf_q   <= bus.ovf;
            sh_q    <= mag;
            bcd_q   <= '0;
            shift_q <= '0;
          end
        end
        CONV: begin
          bcd_q   <= dd_next[13:6];
          sh_q    <= dd_next[5:0];
          shift_q <= shift_q + 3'd1;
        end
        COMMIT: begin
          done_q   <= 1'b1;
          dig_q[3] <= SEG_BLANK;
          if (ovf_q) begin
            dig_q[2] <= SEG_BLANK;
            dig_q[1] <= SEG_O;
            dig_q[0] <= SEG_F;
          end else begin
            dig_q[2] <= neg_q ? SEG_MINUS : SEG_BLANK;
            dig_q[1] <= (bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg_of(bcd_q[7:4]);
            dig_q[0] <= seg_of(bcd_q[3:0]);
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.an_n  = ~(4'b0001 << idx_q);
  assign bus.seg_n = dig_q[idx_q];
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_signed_result_display.sv
// Scoreboard bench: each accepted load pushes its expected four digit codes;
// a monitor pops on done and checks one full scan of seg_n against them.
module tb_signed_result_display;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SO = 7'b1000000;
  localparam logic [6:0] SF = 7'b0001110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [27:0] sb_q [$];

  signed_result_display_if bus ();

  signed_result_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one load and check busy/done timing; inj>0 raises a second load
  // (value 9) at load edge + inj, which must be ignored.
  task automatic do_load(input logic [5:0] v, input logic o, input logic [27:0] exp, input int inj);
    @(negedge clk);
    bus.val  = v;
    bus.ovf  = o;
    bus.load = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1 bus.load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == inj) begin
        bus.val  = 6'd9;
        bus.ovf  = 1'b0;
        bus.load = 1'b1;
      end
      @(posedge clk);
      #1 bus.load = 1'b0;
      chk($sformatf("busy_k%0d", k), {31'd0, bus.busy}, (k < 7) ? 32'd1 : 32'd0);
      chk($sformatf("done_k%0d", k), {31'd0, bus.done}, (k == 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1 chk("done_pulse_end", {31'd0, bus.done}, 32'd0);
    repeat (18) @(posedge clk);
  endtask

  // Monitor: on done, pop the expected digits and check a full scan.
  initial begin
    logic [27:0] exp;
    int idx;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          for (int s = 0; s < 16; s++) begin
            if (s > 0) @(negedge clk);
            case (bus.an_n)
              4'b1110: idx = 0;
              4'b1101: idx = 1;
              4'b1011: idx = 2;
              4'b0111: idx = 3;
              default: idx = -1;
            endcase
            if (idx < 0) chk("an_onehot", {28'd0, bus.an_n}, 32'hE);
            else chk($sformatf("seg_d%0d", idx), {25'd0, bus.seg_n},
                     {25'd0, exp[idx*7 +: 7]});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.val  = '0;
    bus.ovf  = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    // Scan after reset: each digit enabled for 4 cycles, all blank.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("rst_an_%0d", k), {28'd0, bus.an_n}, {28'd0, ~(4'b0001 << (k / 4))});
      chk($sformatf("rst_seg_%0d", k), {25'd0, bus.seg_n}, {25'd0, BL});
    end

    do_load(6'b000111, 1'b0, {BL, BL, BL, S7}, 0);
    do_load(6'b100000, 1'b0, {BL, MI, S3, S2}, 0);
    do_load(6'b011111, 1'b0, {BL, BL, S3, S1}, 0);
    do_load(6'b000000, 1'b0, {BL, BL, BL, S0}, 0);
    do_load(6'b111011, 1'b1, {BL, BL, SO, SF}, 0);
    do_load(6'b111111, 1'b0, {BL, MI, BL, S1}, 0);
    do_load(6'b000101, 1'b0, {BL, BL, BL, S5}, 3);

    // Reset four cycles into a conversion of -12.
    @(negedge clk);
    bus.val  = 6'b110100;
    bus.ovf  = 1'b0;
    bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_an", {28'd0, bus.an_n}, 32'hE);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_seg", {25'd0, bus.seg_n}, {25'd0, BL});
    end

    do_load(6'b110100, 1'b0, {BL, MI, S1, S2}, 0);

    repeat (20) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
